// File: rtl/lbc_stream_encoder.sv
// lbc_stream_encoder
// Systematic (K+P, K) linear block encoder with valid/ready streaming.
// K message bits arrive as K/W beats, with the first beat in the low bits.
// The P parity bits come from a registered AND/XOR tree. Message bits travel
// through the same stages as the tree, so message and parity stay aligned.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   in_data / in_sop are valid
//   in_ready   beat is accepted on the clock edge when in_valid & in_ready
//   in_data    W-bit message beat
//   in_sop     marks the first beat of a message
//   out_valid  out_cw is valid
//   out_ready  downstream takes out_cw when out_valid & out_ready
//   out_cw     {msg[K-1:0], parity[P-1:0]}
//   sync_err   one-cycle pulse when in_sop discards a partial message
module lbc_stream_encoder #(
    parameter int K           = 32,
    parameter int W           = 8,
    parameter int P           = 6,
    parameter int PIPE_STAGES = 2,
    parameter logic [P*K-1:0] PARITY_MASK = {32'hFC000000, 32'h03FFF800, 32'h03FC07F0,
                                             32'hE3C3C78E, 32'h9B33366D, 32'h56AAAD5B}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_sop,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K+P-1:0] out_cw,
    output logic           sync_err
);

    localparam int BEATS  = K / W;
    localparam int IDXW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LEVELS = (K > 1) ? $clog2(K) : 1;
    localparam int NST    = PIPE_STAGES + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BEATS - 1);

    // Tree level reached after register stage s.
    // The stages split the log2(K) levels as evenly as integer division allows.
    function automatic int level_at(input int s);
        if (PIPE_STAGES == 0) return 0;
        return (s * LEVELS) / PIPE_STAGES;
    endfunction

    logic [IDXW-1:0] beat_idx;
    logic [IDXW-1:0] eff_idx;
    logic [IDXW-1:0] next_idx;
    logic [K-1:0]    msg_buf;
    logic [K-1:0]    new_msg;
    logic            advance;
    logic            accept;
    logic            resync;
    logic            launch;
    logic [P-1:0]    parity;

    // Stage 0 holds the launched message and its AND terms.
    // Each later stage holds partially folded XOR terms.
    logic [K-1:0] msg_q  [NST];
    logic         vld_q  [NST];
    logic [K-1:0] part_q [NST][P];
    logic [K-1:0] part_d [NST][P];

    // The whole pipeline, including the input side, moves only when the
    // output register is free or is being drained this cycle.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;
    assign accept   = in_valid && in_ready;

    // Beat assembly.
    // An in_sop beat in the middle of a message restarts assembly from beat 0.
    always_comb begin
        resync  = accept && in_sop && (beat_idx != '0);
        eff_idx = resync ? '0 : beat_idx;
        new_msg = resync ? '0 : msg_buf;
        new_msg[eff_idx*W +: W] = in_data;
        launch  = accept && (eff_idx == LAST_IDX);
        next_idx = beat_idx;
        if (accept) begin
            next_idx = launch ? '0 : eff_idx + 1'b1;
        end
    end

    // XOR-tree folding.
    // Stage s reduces groups of 2^(level_at(s)-level_at(s-1)) terms from the
    // previous stage into one term. Unused high terms stay zero.
    always_comb begin
        int sh;
        sh = 0;
        for (int s = 0; s < NST; s++) begin
            for (int i = 0; i < P; i++) begin
                part_d[s][i] = '0;
            end
        end
        for (int i = 0; i < P; i++) begin
            part_d[0][i] = new_msg & PARITY_MASK[i*K +: K];
        end
        for (int s = 1; s < NST; s++) begin
            sh = level_at(s) - level_at(s - 1);
            for (int i = 0; i < P; i++) begin
                for (int b = 0; b < K; b++) begin
                    part_d[s][i][b >> sh] = part_d[s][i][b >> sh] ^ part_q[s-1][i][b];
                end
            end
        end
    end

    // Final reduction of whatever the last stage has left, in front of the output register.
    always_comb begin
        parity = '0;
        for (int i = 0; i < P; i++) begin
            parity[i] = ^part_q[NST-1][i];
        end
    end

    // State, pipeline and output registers.
    // out_cw reloads only for a valid codeword, so it holds still during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx  <= '0;
            msg_buf   <= '0;
            sync_err  <= 1'b0;
            out_valid <= 1'b0;
            out_cw    <= '0;
            for (int s = 0; s < NST; s++) begin
                vld_q[s] <= 1'b0;
                msg_q[s] <= '0;
                for (int i = 0; i < P; i++) begin
                    part_q[s][i] <= '0;
                end
            end
        end else begin
            sync_err <= resync;
            beat_idx <= next_idx;
            if (accept) begin
                msg_buf <= new_msg;
            end
            if (advance) begin
                vld_q[0] <= launch;
                msg_q[0] <= new_msg;
                for (int i = 0; i < P; i++) begin
                    part_q[0][i] <= part_d[0][i];
                end
                for (int s = 1; s < NST; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    msg_q[s] <= msg_q[s-1];
                    for (int i = 0; i < P; i++) begin
                        part_q[s][i] <= part_d[s][i];
                    end
                end
                out_valid <= vld_q[NST-1];
                if (vld_q[NST-1]) begin
                    out_cw <= {msg_q[NST-1], parity};
                end
            end
        end
    end

endmodule

// File: tb/tb_lbc_stream_encoder.sv
// tb_lbc_stream_encoder
// Self-checking bench for lbc_stream_encoder.
// The default instance is checked by a scoreboard built from the parity-row
// definition. A small K=8/W=4/P=1 instance is also built.
module tb_lbc_stream_encoder;

    localparam logic [191:0] MASK = {32'hFC000000, 32'h03FFF800, 32'h03FC07F0,
                                     32'hE3C3C78E, 32'h9B33366D, 32'h56AAAD5B};

    typedef struct {
        logic [31:0] msg;
        logic [37:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, in_sop, out_valid, out_ready, sync_err;
    logic [7:0]  in_data;
    logic [37:0] out_cw;

    logic        in_valid2, in_ready2, in_sop2, out_valid2, out_ready2, sync_err2;
    logic [3:0]  in_data2;
    logic [8:0]  out_cw2;

    int total = 0;
    int bad   = 0;

    lbc_stream_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sop(in_sop), .out_valid(out_valid),
        .out_ready(out_ready), .out_cw(out_cw), .sync_err(sync_err)
    );

    lbc_stream_encoder #(.K(8), .W(4), .P(1), .PIPE_STAGES(0), .PARITY_MASK(8'hFF)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_sop(in_sop2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_cw(out_cw2), .sync_err(sync_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: each parity bit is the parity of the ones under its mask row.
    function automatic logic [37:0] encode(input logic [31:0] m);
        logic [5:0] p;
        for (int i = 0; i < 6; i++) begin
            p[i] = ($countones(m & MASK[i*32 +: 32]) % 2) == 1;
        end
        return {m, p};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard state: expected codewords in order, plus the message being assembled.
    logic [37:0] exp_q[$];
    logic [31:0] model_buf;
    int          model_cnt = 0;
    logic        sync_pend = 1'b0;
    logic        stall_prev = 1'b0;
    logic [37:0] prev_cw;
    logic [37:0] last_cw;
    int          n_out = 0;
    int          n_sync = 0;
    logic        rand_on = 1'b0;

    // Sample in the middle of the cycle; inputs are stable until the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_buf  = '0;
            model_cnt  = 0;
            sync_pend  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            checkOutput("sync_err", 64'(sync_err), 64'(sync_pend));
            if (sync_err) n_sync++;
            if (stall_prev && out_valid) checkOutput("stall_hold_cw", 64'(out_cw), 64'(prev_cw));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_cw", 64'(out_cw), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    checkOutput("scoreboard_cw", 64'(out_cw), 64'(exp_q.pop_front()));
                end
                last_cw = out_cw;
                n_out++;
            end
            stall_prev = out_valid && !out_ready;
            prev_cw    = out_cw;
            sync_pend  = 1'b0;
            if (in_valid && in_ready) begin
                if (in_sop && model_cnt != 0) begin
                    model_cnt = 0;
                    model_buf = '0;
                    sync_pend = 1'b1;
                end
                model_buf[model_cnt*8 +: 8] = in_data;
                model_cnt++;
                if (model_cnt == 4) begin
                    exp_q.push_back(encode(model_buf));
                    model_cnt = 0;
                end
            end
        end
    end

    // Randomised backpressure, active only during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_on) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic s);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                checkOutput("beat_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_cw", 64'(out_cw), 64'd0);
        checkOutput("rst_sync_err", 64'(sync_err), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    vec_t        tbl[4];
    int          lat;
    int          n0;
    int          s0;
    logic [37:0] cw1;
    logic [31:0] m;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sop = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; in_sop2 = 1'b0; out_ready2 = 1'b1;

        // Hand-derived codewords from the mask rows.
        tbl[0] = '{32'h00000001, 38'h0000000043};
        tbl[1] = '{32'h00000000, 38'h0000000000};
        tbl[2] = '{32'h80000000, 38'h2000000026};
        tbl[3] = '{32'hFFFFFFFF, 38'h3FFFFFFFD8};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_out_valid", 64'(out_valid), 64'd0);
        checkOutput("init_out_cw", 64'(out_cw), 64'd0);
        checkOutput("init_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("init_in_ready_after", 64'(in_ready), 64'd1);
        checkOutput("init_in_ready2_after", 64'(in_ready2), 64'd1);

        // Table vectors: codeword value, 3-cycle latency, single-cycle valid.
        for (int v = 0; v < 4; v++) begin
            m = tbl[v].msg;
            for (int b = 0; b < 4; b++) applyStimulus(m[b*8 +: 8], 1'b0);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 20);
            checkOutput("table_latency", 64'(lat), 64'd4);
            checkOutput("table_cw", 64'(out_cw), 64'(tbl[v].exp));
            @(negedge clk);
            checkOutput("table_valid_pulse", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end

        // Backpressure: two codewords with the output stalled for 10 cycles.
        n0 = n_out;
        out_ready = 1'b0;
        fork
            begin
                for (int b = 0; b < 8; b++) applyStimulus(8'hA0 + 8'(b), 1'b0);
            end
            begin
                lat = 0;
                while (!out_valid && lat < 50) begin
                    @(negedge clk);
                    lat++;
                end
                cw1 = out_cw;
                checkOutput("stall_first_cw", 64'(cw1), 64'(encode(32'hA3A2A1A0)));
                repeat (10) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
                    checkOutput("stall_cw_fixed", 64'(out_cw), 64'(cw1));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        checkOutput("stall_count", 64'(n_out - n0), 64'd2);
        checkOutput("stall_last_cw", 64'(last_cw), 64'(encode(32'hA7A6A5A4)));
        @(posedge clk);
        #1;

        // Resync: in_sop on the third beat drops the partial message.
        n0 = n_out;
        s0 = n_sync;
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("resync_pulses", 64'(n_sync - s0), 64'd1);
        checkOutput("resync_count", 64'(n_out - n0), 64'd1);
        checkOutput("resync_cw", 64'(last_cw), 64'h43);
        @(posedge clk);
        #1;

        // Reset mid-message and with a codeword in the pipeline.
        n0 = n_out;
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        doReset();
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'h66, 1'b0);
        doReset();
        repeat (6) @(negedge clk);
        checkOutput("reset_drop_count", 64'(n_out - n0), 64'd0);
        @(posedge clk);
        #1;
        for (int b = 1; b <= 4; b++) applyStimulus(8'(b), 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("reset_after_count", 64'(n_out - n0), 64'd1);
        checkOutput("reset_after_cw", 64'(last_cw), 64'(encode(32'h04030201)));
        @(posedge clk);
        #1;

        // Small code: K=8, W=4, P=1, no tree registers, beats 3 then 1.
        // The message is 8'h13, which has three ones, so its parity bit is 1.
        in_valid2 = 1'b1;
        in_data2  = 4'h3;
        @(negedge clk);
        checkOutput("small_in_ready", 64'(in_ready2), 64'd1);
        @(posedge clk);
        #1;
        in_data2 = 4'h1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid2 && lat < 20);
        checkOutput("small_latency", 64'(lat), 64'd2);
        checkOutput("small_cw", 64'(out_cw2),
                    64'({8'h13, 1'(($countones(8'h13 & 8'hFF) % 2) == 1)}));
        checkOutput("small_cw_const", 64'(out_cw2), 64'h027);
        checkOutput("small_sync_err", 64'(sync_err2), 64'd0);
        @(posedge clk);
        #1;

        // Random traffic with gaps, occasional in_sop and random backpressure.
        rand_on = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            applyStimulus(8'($urandom), $urandom_range(0, 9) == 0);
        end
        rand_on = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("random_drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
